// File: rtl/hockey_display.sv
// rtl/hockey_display.sv - air-hockey output stage: 8-digit seven-segment scan, serve LEDs, puck column bar
module hockey_display #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd,
    input  logic [2:0] x_coord,
    input  logic [2:0] y_coord,
    input  logic [1:0] score_a,
    input  logic [1:0] score_b,
    input  logic [2:0] phase,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       led_a,
    output logic       led_b,
    output logic [4:0] ledx
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [2:0] PH_SERVE_A = 3'd1;
    localparam logic [2:0] PH_SERVE_B = 3'd2;
    localparam logic [2:0] PH_PLAY    = 3'd3;
    localparam logic [2:0] PH_GOAL_A  = 3'd4;
    localparam logic [2:0] PH_GOAL_B  = 3'd5;
    localparam logic [2:0] PH_WIN     = 3'd6;

    localparam logic [6:0] GL_DASH  = 7'h40;
    localparam logic [6:0] GL_BLANK = 7'h00;
    localparam logic [6:0] GL_A     = 7'h77;
    localparam logic [6:0] GL_B     = 7'h7C;
    localparam logic [6:0] GL_G     = 7'h3D;
    localparam logic [6:0] GL_O     = 7'h3F;
    localparam logic [6:0] GL_L     = 7'h38;

    function automatic logic [6:0] f_num(input logic [2:0] v);
        case (v)
            3'd0:    f_num = 7'h3F;
            3'd1:    f_num = 7'h06;
            3'd2:    f_num = 7'h5B;
            3'd3:    f_num = 7'h4F;
            3'd4:    f_num = 7'h66;
            3'd5:    f_num = 7'h6D;
            3'd6:    f_num = 7'h7D;
            default: f_num = 7'h07;
        endcase
    endfunction

    logic [2:0]    r_x;
    logic [2:0]    r_y;
    logic [1:0]    r_score_a;
    logic [1:0]    r_score_b;
    logic [2:0]    r_phase;
    logic [SW-1:0] r_scan;
    logic [2:0]    r_dig;
    logic [FW-1:0] r_frame;
    logic          r_blink;

    logic          w_phase_change;
    logic          w_scan_wrap;
    logic          w_frame_tick;
    logic          w_live;
    logic          w_goal;
    logic          w_win;
    logic          w_a_wins;
    logic [6:0]    w_glyph;
    logic [7:0]    w_an;
    logic          w_led_a;
    logic          w_led_b;
    logic [4:0]    w_ledx;

    assign w_phase_change = upd && (phase != r_phase);
    assign w_scan_wrap    = (r_scan == SCAN_LAST);
    assign w_frame_tick   = w_scan_wrap && (r_dig == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x       <= 3'd0;
            r_y       <= 3'd0;
            r_score_a <= 2'd0;
            r_score_b <= 2'd0;
            r_phase   <= 3'd0;
        end else if (upd) begin
            r_x       <= x_coord;
            r_y       <= y_coord;
            r_score_a <= score_a;
            r_score_b <= score_b;
            r_phase   <= phase;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_dig  <= 3'd0;
        end else if (w_scan_wrap) begin
            r_scan <= '0;
            r_dig  <= r_dig + 3'd1;
        end else begin
            r_scan <= r_scan + SW'(1);
        end
    end

    // A fresh phase always opens with a full visible half-period, even on a frame wrap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= '0;
            r_blink <= 1'b1;
        end else if (w_phase_change) begin
            r_frame <= '0;
            r_blink <= 1'b1;
        end else if (w_frame_tick) begin
            if (r_frame == FRAME_LAST) begin
                r_frame <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_frame <= r_frame + FW'(1);
            end
        end
    end

    assign w_live   = (r_phase == PH_SERVE_A) || (r_phase == PH_SERVE_B) || (r_phase == PH_PLAY);
    assign w_goal   = (r_phase == PH_GOAL_A) || (r_phase == PH_GOAL_B);
    assign w_win    = (r_phase == PH_WIN);
    assign w_a_wins = (r_score_a == 2'd3);

    always_comb begin
        w_glyph = GL_DASH;
        if (w_live) begin
            case (r_dig)
                3'd7:    w_glyph = f_num({1'b0, r_score_a});
                3'd6:    w_glyph = GL_DASH;
                3'd5:    w_glyph = f_num({1'b0, r_score_b});
                3'd1:    w_glyph = f_num(r_x);
                3'd0:    w_glyph = f_num(r_y);
                default: w_glyph = GL_BLANK;
            endcase
        end else if (w_goal) begin
            case (r_dig)
                3'd7:    w_glyph = GL_G;
                3'd6:    w_glyph = GL_O;
                3'd5:    w_glyph = GL_A;
                3'd4:    w_glyph = GL_L;
                3'd3:    w_glyph = f_num({1'b0, r_score_a});
                3'd2:    w_glyph = GL_DASH;
                3'd1:    w_glyph = f_num({1'b0, r_score_b});
                default: w_glyph = GL_BLANK;
            endcase
            if (!r_blink) begin
                w_glyph = GL_BLANK;
            end
        end else if (w_win) begin
            w_glyph = r_blink ? (w_a_wins ? GL_A : GL_B) : GL_BLANK;
        end
    end

    assign w_an    = ~(8'd1 << r_dig);
    assign w_led_a = (r_phase == PH_SERVE_A) || (w_win && w_a_wins);
    assign w_led_b = (r_phase == PH_SERVE_B) || (w_win && !w_a_wins);
    assign w_ledx  = (w_live && (r_x <= 3'd4)) ? (5'd1 << r_x) : 5'd0;

    // Anode and segment registers load together so a digit never shows its neighbour's glyph.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an    <= 8'hFF;
            seg   <= 7'h7F;
            led_a <= 1'b0;
            led_b <= 1'b0;
            ledx  <= 5'd0;
        end else begin
            an    <= w_an;
            seg   <= ~w_glyph;
            led_a <= w_led_a;
            led_b <= w_led_b;
            ledx  <= w_ledx;
        end
    end

endmodule

// File: tb/tb_hockey_display.sv
// tb/tb_hockey_display.sv - randomized self-checking bench for hockey_display against a cycle-count reference model
module tb_hockey_display;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = 8 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       upd = 1'b0;
    logic [2:0] x_coord = 3'd0;
    logic [2:0] y_coord = 3'd0;
    logic [1:0] score_a = 2'd0;
    logic [1:0] score_b = 2'd0;
    logic [2:0] phase = 3'd0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       led_a;
    logic       led_b;
    logic [4:0] ledx;

    hockey_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .upd(upd),
        .x_coord(x_coord), .y_coord(y_coord),
        .score_a(score_a), .score_b(score_b), .phase(phase),
        .an(an), .seg(seg), .led_a(led_a), .led_b(led_b), .ledx(ledx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: m_c counts edges since reset, m_frames counts frames since the last blink restart.
    int         m_c;
    int         m_frames;
    int         m_d;
    bit         m_bl;
    logic [2:0] m_x, m_y, m_ph;
    logic [1:0] m_sa, m_sb;
    logic [7:0] m_an;
    logic [6:0] m_seg;
    logic       m_la, m_lb;
    logic [4:0] m_lx;

    logic [21:0] obs, want;
    assign obs  = {an, seg, led_a, led_b, ledx};
    assign want = {m_an, m_seg, m_la, m_lb, m_lx};

    logic [7:0] play_segs [8] = '{8'hF9, 8'hBF, 8'hA4, 8'h7F, 8'h7F, 8'h7F, 8'hA4, 8'h99};

    function automatic logic [6:0] num(input logic [2:0] v);
        logic [6:0] t [8];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
        return t[v];
    endfunction

    function automatic logic [6:0] ref_glyph(input logic [2:0] ph, input logic [1:0] sa, input logic [1:0] sb,
                                             input logic [2:0] x, input logic [2:0] y, input int d, input bit bl);
        logic [6:0] live [8];
        logic [6:0] goal [8];
        live = '{num(y), num(x), 7'h00, 7'h00, 7'h00, num({1'b0, sb}), 7'h40, num({1'b0, sa})};
        goal = '{7'h00, num({1'b0, sb}), 7'h40, num({1'b0, sa}), 7'h38, 7'h77, 7'h3F, 7'h3D};
        if (ph >= 3'd1 && ph <= 3'd3) return live[d];
        if (ph == 3'd4 || ph == 3'd5) return bl ? goal[d] : 7'h00;
        if (ph == 3'd6) return bl ? ((sa == 2'd3) ? 7'h77 : 7'h7C) : 7'h00;
        return 7'h40;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_c = 0; m_frames = 0;
            m_x = 0; m_y = 0; m_ph = 0; m_sa = 0; m_sb = 0;
            m_an = 8'hFF; m_seg = 7'h7F; m_la = 0; m_lb = 0; m_lx = 0;
        end else begin
            m_d  = (m_c / SD) % 8;
            m_bl = ((m_frames / BF) % 2) == 0;
            m_an  = 8'hFF ^ (8'h01 << m_d);
            m_seg = ~ref_glyph(m_ph, m_sa, m_sb, m_x, m_y, m_d, m_bl);
            m_la  = (m_ph == 3'd1) || (m_ph == 3'd6 && m_sa == 2'd3);
            m_lb  = (m_ph == 3'd2) || (m_ph == 3'd6 && m_sa != 2'd3);
            m_lx  = (m_ph >= 3'd1 && m_ph <= 3'd3 && m_x <= 3'd4) ? (5'b00001 << m_x) : 5'd0;
            if (upd && phase != m_ph) m_frames = 0;
            else if (m_c % FRAME == FRAME - 1) m_frames = m_frames + 1;
            if (upd) begin
                m_x = x_coord; m_y = y_coord; m_sa = score_a; m_sb = score_b; m_ph = phase;
            end
            m_c = m_c + 1;
        end
    end

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== {8'hFF, 7'h7F, 7'd0}) begin
            n_fail++; $display("FAIL reset_values got %h want %h", obs, {8'hFF, 7'h7F, 7'd0});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FRAME + 2 * SD; i++) begin
            logic [7:0] e_an;
            @(negedge clk);
            e_an = 8'hFF ^ (8'h01 << ((i / SD) % 8));
            n_tests++;
            if (an !== e_an || seg !== 7'h3F || {led_a, led_b, ledx} !== 7'd0) begin
                n_fail++; $display("FAIL idle_scan cyc %0d got an=%h seg=%h leds=%b want an=%h seg=3f leds=0", i, an, seg, {led_a, led_b, ledx}, e_an);
            end
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL idle_model got %h want %h", obs, want); end
        end
    endtask

    task automatic test_play;
        @(negedge clk);
        x_coord = 3'd2; y_coord = 3'd4; score_a = 2'd1; score_b = 2'd2; phase = 3'd3; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ledx !== 5'b00100 || led_a !== 1'b0 || led_b !== 1'b0) begin
            n_fail++; $display("FAIL play_leds got ledx=%b la=%b lb=%b want 00100 0 0", ledx, led_a, led_b);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            int d;
            @(negedge clk);
            d = 0;
            for (int k = 0; k < 8; k++) if (an[k] == 1'b0) d = k;
            n_tests++;
            if (seg !== play_segs[7 - d][6:0]) begin
                n_fail++; $display("FAIL play_digit %0d got seg=%h want %h", d, seg, play_segs[7 - d][6:0]);
            end
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL play_model got %h want %h", obs, want); end
        end
    endtask

    task automatic test_goal;
        int saw_g;
        int saw_blank;
        saw_g = 0; saw_blank = 0;
        @(negedge clk);
        phase = 3'd4; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(negedge clk);
            if (an == 8'h7F) begin
                if (seg == 7'h42) saw_g++;
                else if (seg == 7'h7F) saw_blank++;
                else begin n_tests++; n_fail++; $display("FAIL goal_digit7 got seg=%h want 42 or 7f", seg); end
            end
            n_tests++;
            if (ledx !== 5'd0) begin n_fail++; $display("FAIL goal_ledx got %b want 00000", ledx); end
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL goal_model got %h want %h", obs, want); end
        end
        n_tests++;
        if (saw_g == 0 || saw_blank == 0) begin
            n_fail++; $display("FAIL goal_blink got g=%0d blank=%0d want both nonzero", saw_g, saw_blank);
        end
    endtask

    task automatic test_win;
        for (int w = 0; w < 2; w++) begin
            logic [6:0] e_seg;
            int saw;
            saw = 0;
            @(negedge clk);
            phase = 3'd6; score_a = (w == 0) ? 2'd3 : 2'd1; score_b = (w == 0) ? 2'd1 : 2'd3; upd = 1'b1;
            @(negedge clk);
            upd = 1'b0;
            @(negedge clk);
            e_seg = (w == 0) ? 7'h08 : 7'h03;
            n_tests++;
            if (led_a !== (w == 0) || led_b !== (w == 1)) begin
                n_fail++; $display("FAIL win_leds %0d got la=%b lb=%b want %b %b", w, led_a, led_b, w == 0, w == 1);
            end
            for (int i = 0; i < 3 * FRAME; i++) begin
                @(negedge clk);
                if (seg !== 7'h7F) begin
                    saw++;
                    n_tests++;
                    if (seg !== e_seg) begin n_fail++; $display("FAIL win_glyph %0d got %h want %h", w, seg, e_seg); end
                end
                n_tests++;
                if (obs !== want) begin n_fail++; $display("FAIL win_model got %h want %h", obs, want); end
            end
            n_tests++;
            if (saw == 0) begin n_fail++; $display("FAIL win_visible %0d got 0 lit cycles want >0", w); end
        end
    endtask

    task automatic test_restrobe;
        int guard;
        @(negedge clk);
        phase = 3'd5; score_a = 2'd2; score_b = 2'd1; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        guard = 0;
        while (((m_frames / BF) % 2) != 1 && guard < 400) begin
            @(negedge clk); guard++;
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL restrobe_model got %h want %h", obs, want); end
        end
        n_tests++;
        if (((m_frames / BF) % 2) != 1) begin n_fail++; $display("FAIL restrobe_wait_off got timeout want blink off"); end
        upd = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            upd = 1'b0;
            n_tests++;
            if (seg !== 7'h7F) begin n_fail++; $display("FAIL restrobe_no_restart cyc %0d got seg=%h want 7f", i, seg); end
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL restrobe_model got %h want %h", obs, want); end
        end
        guard = 0;
        while (!((m_c % FRAME == FRAME - 1) && (m_frames % (2 * BF) == BF - 1)) && guard < 400) begin
            @(negedge clk); guard++;
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL wrap_model got %h want %h", obs, want); end
        end
        n_tests++;
        if (!((m_c % FRAME == FRAME - 1) && (m_frames % (2 * BF) == BF - 1))) begin
            n_fail++; $display("FAIL wrap_wait got timeout want frame wrap");
        end
        phase = 3'd4; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL wrap_model got %h want %h", obs, want); end
        end
        n_tests++;
        if (an !== 8'hFD || seg !== ~num(3'd1)) begin
            n_fail++; $display("FAIL wrap_blink_on got an=%h seg=%h want fd %h", an, seg, ~num(3'd1));
        end
    endtask

    task automatic test_reset_mid;
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_c % FRAME != 5 * SD + 2 && guard < 100) begin @(negedge clk); guard++; end
        n_tests++;
        if (m_c % FRAME != 5 * SD + 2) begin n_fail++; $display("FAIL midreset_wait got timeout want digit 5"); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== {8'hFF, 7'h7F, 7'd0}) begin
            n_fail++; $display("FAIL midreset_async got %h want %h", obs, {8'hFF, 7'h7F, 7'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (an !== 8'hFE || seg !== 7'h3F || ledx !== 5'd0) begin
            n_fail++; $display("FAIL midreset_release got an=%h seg=%h ledx=%b want fe 3f 00000", an, seg, ledx);
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== want) begin n_fail++; $display("FAIL midreset_model got %h want %h", obs, want); end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            int hold;
            int run;
            @(negedge clk);
            x_coord = 3'($urandom_range(0, 7));
            y_coord = 3'($urandom_range(0, 7));
            score_a = 2'($urandom_range(0, 3));
            score_b = 2'($urandom_range(0, 3));
            phase   = 3'($urandom_range(0, 7));
            upd = 1'b1;
            hold = $urandom_range(1, 3);
            run  = $urandom_range(2, 80);
            for (int i = 0; i < hold + run; i++) begin
                @(negedge clk);
                if (i + 1 >= hold) upd = 1'b0;
                n_tests++;
                if (obs !== want) begin n_fail++; $display("FAIL random_model it %0d got %h want %h", it, obs, want); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_play;
        test_goal;
        test_win;
        test_restrobe;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
